// File: rtl/bayer_scan_sequencer.sv
// Raster sequencer feeding the Bayer-to-RGB888 converter: scan counters, FIFO pops and aligned syncs.
// Optional per-frame underflow pixel counter: define BAYER_SEQ_UNDERFLOW_CNT_EN.
module bayer_scan_sequencer #(
    parameter int H_ACTIVE = 1280,
    parameter int H_TOTAL  = 1650,
    parameter int HS_START = 1390,
    parameter int HS_LEN   = 40,
    parameter int V_ACTIVE = 720,
    parameter int V_TOTAL  = 750,
    parameter int VS_START = 725,
    parameter int VS_LEN   = 5
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic        fifo_empty,
    input  logic [15:0] fifo_data,
    output logic        fifo_rd_en,
    output logic [15:0] bayer_data,
    output logic [11:0] pixel_x,
    output logic [11:0] pixel_y,
    output logic        de_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        frame_start,
    output logic        underflow
`ifdef BAYER_SEQ_UNDERFLOW_CNT_EN
    ,
    output logic [15:0] underflow_cnt
`endif
);

    localparam logic [11:0] H_ACT12  = 12'(H_ACTIVE);
    localparam logic [11:0] H_LAST12 = 12'(H_TOTAL - 1);
    localparam logic [11:0] HS_BEG12 = 12'(HS_START);
    localparam logic [11:0] HS_END12 = 12'(HS_START + HS_LEN);
    localparam logic [11:0] V_ACT12  = 12'(V_ACTIVE);
    localparam logic [11:0] V_LAST12 = 12'(V_TOTAL - 1);
    localparam logic [11:0] VS_BEG12 = 12'(VS_START);
    localparam logic [11:0] VS_END12 = 12'(VS_START + VS_LEN);
    localparam int          SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [11:0] h_cnt_reg;
    logic [11:0] v_cnt_reg;
    logic [15:0] bayer_data_reg;
    logic [11:0] pixel_x_reg;
    logic [11:0] pixel_y_reg;
    logic        frame_start_reg;
    logic        underflow_reg;

    // Bit 2 = data enable, bit 1 = hsync, bit 0 = vsync.
    logic [2:0]  sync_pipe_reg [SYNC_STAGES];

    logic        in_run;
    logic        active;
    logic        hs_comb;
    logic        vs_comb;
    logic        pop;
    logic        underflow_set;
    logic        frame_start_next;
    logic        h_wrap;
    logic        v_wrap;

    assign in_run           = (state_reg == RUN);
    assign active           = in_run && (h_cnt_reg < H_ACT12) && (v_cnt_reg < V_ACT12);
    assign hs_comb          = in_run && (h_cnt_reg >= HS_BEG12) && (h_cnt_reg < HS_END12);
    assign vs_comb          = in_run && (v_cnt_reg >= VS_BEG12) && (v_cnt_reg < VS_END12);
    assign pop              = active && !fifo_empty;
    assign underflow_set    = active && fifo_empty;
    assign frame_start_next = in_run && (h_cnt_reg == 12'd0) && (v_cnt_reg == 12'd0);
    assign h_wrap           = (h_cnt_reg == H_LAST12);
    assign v_wrap           = (v_cnt_reg == V_LAST12);

    assign fifo_rd_en = pop;

    // Scan FSM. enable is only honoured at the very last clock of a frame so frames never truncate.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            h_cnt_reg <= 12'd0;
            v_cnt_reg <= 12'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    h_cnt_reg <= 12'd0;
                    v_cnt_reg <= 12'd0;
                    if (enable) begin
                        state_reg <= ARM;
                    end
                end
                ARM: begin
                    h_cnt_reg <= 12'd0;
                    v_cnt_reg <= 12'd0;
                    if (!enable) begin
                        state_reg <= IDLE;
                    end else if (!fifo_empty) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (h_wrap) begin
                        h_cnt_reg <= 12'd0;
                        if (v_wrap) begin
                            v_cnt_reg <= 12'd0;
                            if (!enable) begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            v_cnt_reg <= v_cnt_reg + 12'd1;
                        end
                    end else begin
                        h_cnt_reg <= h_cnt_reg + 12'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    h_cnt_reg <= 12'd0;
                    v_cnt_reg <= 12'd0;
                end
            endcase
        end
    end

    // Stage 1: what the converter sees. A starved pixel is sent as zero; the scan keeps moving.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            bayer_data_reg  <= 16'd0;
            pixel_x_reg     <= 12'd0;
            pixel_y_reg     <= 12'd0;
            frame_start_reg <= 1'b0;
        end else begin
            bayer_data_reg  <= pop ? fifo_data : 16'd0;
            pixel_x_reg     <= h_cnt_reg;
            pixel_y_reg     <= v_cnt_reg;
            frame_start_reg <= frame_start_next;
        end
    end

    // A starved pixel on the first clock of a frame must still be reported for that frame.
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            underflow_reg <= 1'b0;
        end else if (underflow_set) begin
            underflow_reg <= 1'b1;
        end else if (frame_start_next) begin
            underflow_reg <= 1'b0;
        end
    end

`ifdef BAYER_SEQ_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt_reg;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            underflow_cnt_reg <= 16'd0;
        end else if (frame_start_next) begin
            underflow_cnt_reg <= underflow_set ? 16'd1 : 16'd0;
        end else if (underflow_set && (underflow_cnt_reg != 16'hFFFF)) begin
            underflow_cnt_reg <= underflow_cnt_reg + 16'd1;
        end
    end

    assign underflow_cnt = underflow_cnt_reg;
`endif

    // Two-deep delay of de/hs/vs: one for stage 1, one for the converter's output register.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : gen_sync_pipe
            if (gi == 0) begin : gen_head
                always_ff @(posedge pclk or negedge rst) begin
                    if (!rst) begin
                        sync_pipe_reg[gi] <= 3'b000;
                    end else begin
                        sync_pipe_reg[gi] <= {active, hs_comb, vs_comb};
                    end
                end
            end else begin : gen_tail
                always_ff @(posedge pclk or negedge rst) begin
                    if (!rst) begin
                        sync_pipe_reg[gi] <= 3'b000;
                    end else begin
                        sync_pipe_reg[gi] <= sync_pipe_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign bayer_data  = bayer_data_reg;
    assign pixel_x     = pixel_x_reg;
    assign pixel_y     = pixel_y_reg;
    assign frame_start = frame_start_reg;
    assign underflow   = underflow_reg;
    assign de_out      = sync_pipe_reg[SYNC_STAGES-1][2];
    assign hs_out      = sync_pipe_reg[SYNC_STAGES-1][1];
    assign vs_out      = sync_pipe_reg[SYNC_STAGES-1][0];

endmodule
